// File: rtl/counter8_ctrl.sv
// counter8_ctrl: run controller for the 3-bit display counter.
// Sequences start/pause/resume/clear and prescales the count-enable tick.
module counter8_ctrl #(
    parameter int DIV = 4
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       iStart,
    input  logic       iStop,
    input  logic       iClear,
    input  logic       iDir,
    input  logic       iMode,
    input  logic [2:0] iQ,
    output logic       oCE,
    output logic       oUp,
    output logic       oClr,
    output logic       oBusy,
    output logic       oDone,
    output logic [1:0] oState
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_n;
    logic          ce;
    logic          ce_n;
    logic          up;
    logic          up_n;
    logic          mode;
    logic          mode_n;
    logic          clr;
    logic          clr_n;
    logic          busy;
    logic          done;
    logic          done_n;
    logic          launch;
    logic [2:0]    pre_target;
    logic          at_term;

    // The tick in flight lands the counter on its target on this edge.
    assign pre_target = up ? 3'd6 : 3'd1;
    assign at_term    = ce & mode & (iQ == pre_target);

    always_comb begin
        state_n = state;
        presc_n = presc;
        ce_n    = 1'b0;
        clr_n   = 1'b0;
        done_n  = 1'b0;
        up_n    = up;
        mode_n  = mode;
        launch  = 1'b0;
        if (iClear) begin
            state_n = IDLE;
            presc_n = '0;
            clr_n   = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (iStart) begin
                        state_n = RUN;
                        presc_n = '0;
                        launch  = 1'b1;
                    end
                end
                RUN: begin
                    if (at_term) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        presc_n = '0;
                    end else if (iStop) begin
                        state_n = PAUSE;
                    end else if (presc == LAST) begin
                        presc_n = '0;
                        ce_n    = 1'b1;
                    end else begin
                        presc_n = presc + 1'b1;
                    end
                end
                PAUSE: begin
                    // Resume keeps the prescaler so the tick phase survives.
                    if (iStop) begin
                        state_n = IDLE;
                        presc_n = '0;
                    end else if (iStart) begin
                        state_n = RUN;
                        launch  = 1'b1;
                    end
                end
                DONE: begin
                    if (iStart) begin
                        state_n = RUN;
                        presc_n = '0;
                        launch  = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
        if (launch) begin
            up_n   = iDir;
            mode_n = iMode;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= IDLE;
            presc <= '0;
            ce    <= 1'b0;
            clr   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            up    <= 1'b1;
            mode  <= 1'b0;
        end else begin
            state <= state_n;
            presc <= presc_n;
            ce    <= ce_n;
            clr   <= clr_n;
            busy  <= (state_n == RUN);
            done  <= done_n;
            up    <= up_n;
            mode  <= mode_n;
        end
    end

    assign oCE    = ce;
    assign oUp    = up;
    assign oClr   = clr;
    assign oBusy  = busy;
    assign oDone  = done;
    assign oState = state;

endmodule
